alu_exec_unit: RTL

//  Integer execute stage directly downstream of the reservation station. Takes one ready op per cycle
//  (optype/alias/pc/Vi/Vj/imm), computes the RV32I result and the branch/jump outcome, and registers both.

---
 rtl/alu_exec_pkg.sv | 44 ++++
 rtl/alu_exec_unit_core.sv | 90 +++++++++
 rtl/alu_exec_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared constants for the integer execute stage: optype encodings and default widths.
package alu_exec_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ROB_ID_W_DEF = 5;
    localparam int OPTYPE_W     = 6;
    localparam int OP_COUNT     = 30;

    localparam logic [ROB_ID_W_DEF-1:0] RENAMED_ZERO = '0;

    typedef enum logic [OPTYPE_W-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,
        OP_BLTU  = 6'd9,
        OP_BGEU  = 6'd10,
        OP_ADD   = 6'd11,
        OP_SUB   = 6'd12,
        OP_SLL   = 6'd13,
        OP_SLT   = 6'd14,
        OP_SLTU  = 6'd15,
        OP_XOR   = 6'd16,
        OP_SRL   = 6'd17,
        OP_SRA   = 6'd18,
        OP_OR    = 6'd19,
        OP_AND   = 6'd20,
        OP_ADDI  = 6'd21,
        OP_SLTI  = 6'd22,
        OP_SLTIU = 6'd23,
        OP_XORI  = 6'd24,
        OP_ORI   = 6'd25,
        OP_ANDI  = 6'd26,
        OP_SLLI  = 6'd27,
        OP_SRLI  = 6'd28,
        OP_SRAI  = 6'd29
    } optype_e;

endpackage

// File: rtl/alu_exec_unit_core.sv
// Combinational RV32I datapath: result value plus branch/jump resolution for one op.
module alu_core
    import alu_exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [OPTYPE_W-1:0] optype,
    input  logic [DATA_W-1:0]   pc,
    input  logic [DATA_W-1:0]   vi,
    input  logic [DATA_W-1:0]   vj,
    input  logic [DATA_W-1:0]   imm,
    output logic [DATA_W-1:0]   result,
    output logic                is_jump,
    output logic                taken,
    output logic [DATA_W-1:0]   target
);

    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] pc_imm;
    logic [4:0]        shamt_r;
    logic [4:0]        shamt_i;
    logic              lt_s;
    logic              lt_u;
    logic              eq;

    assign pc_inc  = pc + DATA_W'(4);
    assign pc_imm  = pc + imm;
    assign shamt_r = vj[4:0];
    assign shamt_i = imm[4:0];
    assign lt_s    = $signed(vi) < $signed(vj);
    assign lt_u    = vi < vj;
    assign eq      = vi == vj;

    always_comb begin
        result  = '0;
        is_jump = 1'b0;
        taken   = 1'b0;
        target  = pc_inc;
        case (optype)
            OP_LUI:   result = imm;
            OP_AUIPC: result = pc_imm;
            OP_JAL: begin
                result  = pc_inc;
                is_jump = 1'b1;
                taken   = 1'b1;
                target  = pc_imm;
            end
            OP_JALR: begin
                result  = pc_inc;
                is_jump = 1'b1;
                taken   = 1'b1;
                target  = (vi + imm) & ~DATA_W'(1);
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                is_jump = 1'b1;
                case (optype)
                    OP_BEQ:  taken = eq;
                    OP_BNE:  taken = !eq;
                    OP_BLT:  taken = lt_s;
                    OP_BGE:  taken = !lt_s;
                    OP_BLTU: taken = lt_u;
                    default: taken = !lt_u;
                endcase
                // Branches write no register value; result stays 0.
                target = taken ? pc_imm : pc_inc;
            end
            OP_ADD:   result = vi + vj;
            OP_SUB:   result = vi - vj;
            OP_SLL:   result = vi << shamt_r;
            OP_SLT:   result = DATA_W'(lt_s);
            OP_SLTU:  result = DATA_W'(lt_u);
            OP_XOR:   result = vi ^ vj;
            OP_SRL:   result = vi >> shamt_r;
            OP_SRA:   result = $signed(vi) >>> shamt_r;
            OP_OR:    result = vi | vj;
            OP_AND:   result = vi & vj;
            OP_ADDI:  result = vi + imm;
            OP_SLTI:  result = DATA_W'($signed(vi) < $signed(imm));
            OP_SLTIU: result = DATA_W'(vi < imm);
            OP_XORI:  result = vi ^ imm;
            OP_ORI:   result = vi | imm;
            OP_ANDI:  result = vi & imm;
            OP_SLLI:  result = vi << shamt_i;
            OP_SRLI:  result = vi >> shamt_i;
            OP_SRAI:  result = $signed(vi) >>> shamt_i;
            default:  ;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execute stage: alu_core plus output registers, rollback/rdy control.
// Optional ALU_PERF_EN adds saturating op / taken-branch counters.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ROB_ID_W = ROB_ID_W_DEF,
    parameter int OP_W     = OPTYPE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                rollback_signal,
    input  logic [OP_W-1:0]     optype_from_rs,
    input  logic [ROB_ID_W-1:0] rd_from_rs,
    input  logic [DATA_W-1:0]   pc_from_rs,
    input  logic [DATA_W-1:0]   vi_from_rs,
    input  logic [DATA_W-1:0]   vj_from_rs,
    input  logic [DATA_W-1:0]   imm_from_rs,
    output logic                alu_has_result,
    output logic [ROB_ID_W-1:0] alias_from_alu,
    output logic [DATA_W-1:0]   result_from_alu,
    output logic                alu_is_jump,
    output logic                alu_jump_taken,
    output logic [DATA_W-1:0]   alu_jump_target
`ifdef ALU_PERF_EN
    ,
    output logic [31:0]         perf_op_cnt,
    output logic [31:0]         perf_br_taken_cnt
`endif
);

    logic              in_valid;
    logic              accept;
    logic [DATA_W-1:0] core_result;
    logic              core_is_jump;
    logic              core_taken;
    logic [DATA_W-1:0] core_target;

    // Handshake: an op is valid when optype != NOP and is consumed on any rdy=1 edge
    // without rollback. There is no ready back to the RS; the unit never stalls.
    assign in_valid = optype_from_rs != OP_W'(OP_NOP);
    assign accept   = rdy && !rollback_signal && in_valid;

    alu_core #(.DATA_W(DATA_W)) u_core (
        .optype  (optype_from_rs),
        .pc      (pc_from_rs),
        .vi      (vi_from_rs),
        .vj      (vj_from_rs),
        .imm     (imm_from_rs),
        .result  (core_result),
        .is_jump (core_is_jump),
        .taken   (core_taken),
        .target  (core_target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_has_result  <= 1'b0;
            alias_from_alu  <= '0;
            result_from_alu <= '0;
            alu_is_jump     <= 1'b0;
            alu_jump_taken  <= 1'b0;
            alu_jump_target <= '0;
        end else if (rollback_signal) begin
            alu_has_result <= 1'b0;
            alu_is_jump    <= 1'b0;
        end else if (rdy) begin
            alu_has_result  <= in_valid;
            alias_from_alu  <= rd_from_rs;
            result_from_alu <= core_result;
            alu_is_jump     <= in_valid && core_is_jump;
            alu_jump_taken  <= core_taken;
            alu_jump_target <= core_target;
        end
    end

`ifdef ALU_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_op_cnt       <= '0;
            perf_br_taken_cnt <= '0;
        end else if (accept) begin
            if (perf_op_cnt != '1) perf_op_cnt <= perf_op_cnt + 32'd1;
            if (core_taken && perf_br_taken_cnt != '1)
                perf_br_taken_cnt <= perf_br_taken_cnt + 32'd1;
        end
    end
`endif

endmodule
